// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, state type and helpers for the keypad scanner
package keypad_pkg;

    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 4;
    localparam logic [3:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } kp_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt;
    endfunction

    // Snapshot bit i sits at col*4+row; the reported code is {row, col}.
    function automatic logic [3:0] onehot_to_code(input logic [15:0] v);
        logic [3:0] code;
        logic [3:0] idx;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (v[i]) begin
                code = {idx[1:0], idx[3:2]};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key/entry result bundle
// slave  : the scanner (samples row_n/clear, drives strobes and results)
// master : the keypad/host side
interface keypad_scanner_if;
    logic [3:0]  row_n;
    logic        clear;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        multi_key;
    logic [15:0] entry_data;

    modport slave (
        input  row_n, clear,
        output col_n, key_valid, key_code, key_held, multi_key, entry_data
    );

    modport master (
        output row_n, clear,
        input  col_n, key_valid, key_code, key_held, multi_key, entry_data
    );
endinterface

// File: rtl/keypad_col_strobe.sv
// rtl/keypad_col_strobe.sv - column strobe divider and rotation
// clk, rst_n  : clock, asynchronous active-low reset
// col_n_o     : one-cold column strobe
// col_idx_o   : index of the strobed column
// sample_en_o : last cycle of the current column slot
// scan_done_o : last cycle of column 3 (full scan complete)
module keypad_col_strobe
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n_o,
    output logic [1:0] col_idx_o,
    output logic       sample_en_o,
    output logic       scan_done_o
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    col_q, col_d;
    logic          sample_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            col_q <= COL_IDLE;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        sample_en = (div_q == DW'(SCAN_DIV - 1));
        div_d     = sample_en ? '0 : div_q + 1'b1;
        idx_d     = sample_en ? idx_q + 2'd1 : idx_q;
        col_d     = sample_en ? {col_q[2:0], col_q[3]} : col_q;
    end

    assign col_n_o     = col_q;
    assign col_idx_o   = idx_q;
    assign sample_en_o = sample_en;
    assign scan_done_o = sample_en && (idx_q == 2'(NUM_COLS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce, key FSM and hex entry register
// clk, rst_n : clock, asynchronous active-low reset
// kp         : keypad_scanner_if.slave (row_n, clear in; col_n, key_valid,
//              key_code, key_held, multi_key, entry_data out)
// Optional auto-repeat built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_SCANS   = 64
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    keypad_scanner_if.slave kp
);
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic [3:0] col_n;
    logic [1:0] col_idx;
    logic       sample_en;
    logic       scan_done;

    keypad_col_strobe #(.SCAN_DIV(SCAN_DIV)) u_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_n_o    (col_n),
        .col_idx_o  (col_idx),
        .sample_en_o(sample_en),
        .scan_done_o(scan_done)
    );

    logic [15:0]   snap_q, snap_cur, prev_q, prev_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          accept;
    kp_state_t     state_q, state_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [15:0]   entry_q, entry_d;
    logic [4:0]    nkeys;
    logic [3:0]    new_code;

    // Column 3 is sampled in the same cycle scan_done fires, so the debounce
    // compares against a view of the snapshot that already includes it.
    always_comb begin
        snap_cur = snap_q;
        if (sample_en) begin
            snap_cur[col_idx*NUM_ROWS +: NUM_ROWS] = ~kp.row_n;
        end
        prev_d   = prev_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (scan_done) begin
            prev_d = snap_cur;
            if (snap_cur == prev_q) begin
                stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = '0;
            end
            accept = (stable_d == STABLE_MAX);
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        state_d     = state_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        nkeys       = popcount16(snap_cur);
        new_code    = onehot_to_code(snap_cur);
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (nkeys == 5'd1) begin
                        state_d     = PRESSED;
                        key_valid_d = 1'b1;
                        key_code_d  = new_code;
                    end else if (nkeys > 5'd1) begin
                        state_d = MULTI;
                    end
                end
                PRESSED: begin
                    if (nkeys == 5'd0) begin
                        state_d = IDLE;
                    end else if (nkeys > 5'd1) begin
                        state_d = MULTI;
                    end else if (new_code != key_code_q) begin
                        key_valid_d = 1'b1;
                        key_code_d  = new_code;
                    end
                end
                MULTI: begin
                    if (nkeys == 5'd0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d = rpt_q;
        if ((state_q != PRESSED) || (state_d != state_q)) begin
            rpt_d = '0;
        end else if (scan_done) begin
            if (rpt_q == RPT_MAX) begin
                rpt_d = '0;
                if (!key_valid_d) begin
                    key_valid_d = 1'b1;
                    key_code_d  = key_code_q;
                end
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
`endif
        // Shift uses the registered pulse/code; clear wins over it.
        entry_d = entry_q;
        if (kp.clear) begin
            entry_d = '0;
        end else if (key_valid_q) begin
            entry_d = {entry_q[11:0], key_code_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q      <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            state_q     <= IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            entry_q     <= '0;
        end else begin
            if (sample_en) begin
                snap_q <= snap_cur;
            end
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            entry_q     <= entry_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign kp.col_n      = col_n;
    assign kp.key_valid  = key_valid_q;
    assign kp.key_code   = key_code_q;
    assign kp.key_held   = (state_q == PRESSED);
    assign kp.multi_key  = (state_q == MULTI);
    assign kp.entry_data = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;   // bit row*4+col, 1 = pressed
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          kv_cnt = 0;
    int          kv_last = 0;
    int          kv_prev = 0;
    int          kv0;

    keypad_scanner_if ifc();

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_SCANS  (3)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            ifc.row_n[r] = ~|(keys[r*4 +: 4] & ~ifc.col_n);
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifc.key_valid) begin
            kv_cnt  = kv_cnt + 1;
            kv_prev = kv_last;
            kv_last = cyc;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] col_exp [4];
        int n;
        col_exp[0] = 4'b1110;
        col_exp[1] = 4'b1101;
        col_exp[2] = 4'b1011;
        col_exp[3] = 4'b0111;
        ifc.clear = 1'b0;

        // 1. reset values and free-running column rotation
        repeat (3) @(negedge clk);
        check("rst_col_n", ifc.col_n, 4'b1110);
        check("rst_key_valid", {15'd0, ifc.key_valid}, 16'd0);
        check("rst_key_code", {12'd0, ifc.key_code}, 16'd0);
        check("rst_key_held", {15'd0, ifc.key_held}, 16'd0);
        check("rst_multi", {15'd0, ifc.multi_key}, 16'd0);
        check("rst_entry", ifc.entry_data, 16'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            check("col_rotation", {12'd0, ifc.col_n}, {12'd0, col_exp[(k / 4) % 4]});
            @(negedge clk);
        end
        check("idle_kv_cnt", 16'(kv_cnt), 16'd0);
        check("idle_entry", ifc.entry_data, 16'd0);

        // 2. single press of row1/col2
        keys = 16'h0040;
        wait_scans(4);
        check("p6_kv_cnt", 16'(kv_cnt), 16'd1);
        check("p6_code", {12'd0, ifc.key_code}, 16'h0006);
        check("p6_entry", ifc.entry_data, 16'h0006);
        check("p6_held", {15'd0, ifc.key_held}, 16'd1);
        keys = '0;
        wait_scans(4);
        check("p6_release_held", {15'd0, ifc.key_held}, 16'd0);
        check("p6_release_kv_cnt", 16'(kv_cnt), 16'd1);

        // 3. keys 1..4 then 5
        for (int d = 1; d <= 4; d++) begin
            keys = 16'(1 << d);
            wait_scans(4);
            keys = '0;
            wait_scans(4);
        end
        check("seq_1234", ifc.entry_data, 16'h1234);
        keys = 16'h0020;
        wait_scans(4);
        keys = '0;
        wait_scans(4);
        check("seq_2345", ifc.entry_data, 16'h2345);
        check("seq_kv_cnt", 16'(kv_cnt), 16'd6);

        // 4. bouncing key 0, then stable
        kv0 = kv_cnt;
        for (int i = 0; i < 20; i++) begin
            keys[0] = ~keys[0];
            repeat (5) @(negedge clk);
        end
        check("bounce_no_kv", 16'(kv_cnt - kv0), 16'd0);
        keys = 16'h0001;
        wait_scans(4);
        check("bounce_then_kv", 16'(kv_cnt - kv0), 16'd1);
        check("bounce_code", {12'd0, ifc.key_code}, 16'h0000);
        check("bounce_entry", ifc.entry_data, 16'h3450);
        keys = '0;
        wait_scans(4);

        // 5. two keys on row2 (col1 and col3)
        kv0 = kv_cnt;
        keys = 16'h0A00;
        wait_scans(4);
        check("multi_set", {15'd0, ifc.multi_key}, 16'd1);
        check("multi_not_held", {15'd0, ifc.key_held}, 16'd0);
        keys = 16'h0200;
        wait_scans(4);
        check("multi_one_left", {15'd0, ifc.multi_key}, 16'd1);
        check("multi_one_held", {15'd0, ifc.key_held}, 16'd0);
        keys = '0;
        wait_scans(4);
        check("multi_released", {15'd0, ifc.multi_key}, 16'd0);
        check("multi_no_kv", 16'(kv_cnt - kv0), 16'd0);

        // 6a. clear coincident with key_valid
        keys = 16'h0080;
        n = 0;
        while (!ifc.key_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("clr_kv_seen", {15'd0, ifc.key_valid}, 16'd1);
        ifc.clear = 1'b1;
        @(negedge clk);
        ifc.clear = 1'b0;
        check("clr_entry", ifc.entry_data, 16'h0000);
        check("clr_code", {12'd0, ifc.key_code}, 16'h0007);
        repeat (3) @(negedge clk);
        check("clr_entry_stays", ifc.entry_data, 16'h0000);
        keys = '0;
        wait_scans(4);

        // 6b. asynchronous reset mid-slot while a key is held
        keys = 16'h0020;
        wait_scans(4);
        check("pre_rst_entry", ifc.entry_data, 16'h0005);
        check("pre_rst_held", {15'd0, ifc.key_held}, 16'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_col_n", {12'd0, ifc.col_n}, 16'h000E);
        check("arst_code", {12'd0, ifc.key_code}, 16'd0);
        check("arst_held", {15'd0, ifc.key_held}, 16'd0);
        check("arst_multi", {15'd0, ifc.multi_key}, 16'd0);
        check("arst_valid", {15'd0, ifc.key_valid}, 16'd0);
        check("arst_entry", ifc.entry_data, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6c. long hold of key A
        kv0 = kv_cnt;
        keys = 16'h0400;
        wait_scans(10);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rpt_kv_cnt", 16'(kv_cnt - kv0), 16'd3);
        check("rpt_period", 16'(kv_last - kv_prev), 16'd48);
        check("rpt_entry", ifc.entry_data, 16'h0AAA);
`else
        check("hold_kv_cnt", 16'(kv_cnt - kv0), 16'd1);
        check("hold_entry", ifc.entry_data, 16'h000A);
`endif
        check("hold_code", {12'd0, ifc.key_code}, 16'h000A);
        keys = '0;
        wait_scans(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
